memory_arbiter: RTL and testbench

- Sits directly downstream of the request unit and the instruction-fetch path.
- Arbitrates instruction reads and data reads/writes onto a single-port, variable-latency RAM.
- Returns one-cycle ihit/dhit pulses and holds the loaded words stable until the next hit on the same port.
- Owns all RAM-side handshaking: RAM wait states, RAM error, and a watchdog timeout.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/arb_timer.sv | 31 +++
 rtl/memory_arbiter.sv | 139 +++++++++++++
 tb/tb_memory_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, RAM status encoding and arbiter states.
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;

    typedef logic [CPU_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IREQ = 2'd1,
        DREQ = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// Watchdog counter: clears on grant, counts while enabled, saturates at TIMEOUT-1.
module arb_timer #(
    parameter int TIMEOUT = 64,
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          clear,
    input  logic          enable,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one variable-latency RAM port,
// alternating grants under contention and aborting on RAM error or watchdog expiry.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              err,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t        state, state_nx;
    ramstate_t         rs;
    logic              last_data, last_data_nx;
    logic              op_write;
    logic [WORD_W-1:0] addr_q, store_q;
    logic              dreq, grant_i, grant_d, done, abort, expired;
    logic              ihit_nx, dhit_nx, err_nx;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (grant_i | grant_d),
        .enable   (state != IDLE),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .expired  (expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        last_data_nx = last_data;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        done         = 1'b0;
        abort        = 1'b0;
        ihit_nx      = 1'b0;
        dhit_nx      = 1'b0;
        err_nx       = 1'b0;
        case (state)
            IDLE: begin
                // Under contention the port not served last time wins.
                if (dreq && (!iREN || !last_data)) begin
                    grant_d  = 1'b1;
                    state_nx = DREQ;
                end else if (iREN) begin
                    grant_i  = 1'b1;
                    state_nx = IREQ;
                end
            end
            IREQ, DREQ: begin
                if (rs == ACCESS) begin
                    done = 1'b1;
                end else if (rs == ERROR || expired) begin
                    abort = 1'b1;
                end
                if (done || abort) begin
                    state_nx     = IDLE;
                    last_data_nx = (state == DREQ);
                end
                ihit_nx = done && (state == IREQ);
                dhit_nx = done && (state == DREQ);
                err_nx  = abort;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_data <= 1'b0;
            op_write  <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            err       <= 1'b0;
            iload     <= '0;
            dload     <= '0;
        end else begin
            last_data <= last_data_nx;
            ihit      <= ihit_nx;
            dhit      <= dhit_nx;
            err       <= err_nx;
            if (grant_d) begin
                addr_q   <= daddr;
                store_q  <= dstore;
                op_write <= dWEN;
            end else if (grant_i) begin
                addr_q   <= iaddr;
                op_write <= 1'b0;
            end
            if (ihit_nx) begin
                iload <= ramload;
            end
            if (dhit_nx && !op_write) begin
                dload <= ramload;
            end
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign ramREN   = (state == IREQ) || ((state == DREQ) && !op_write);
    assign ramWEN   = (state == DREQ) && op_write;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// transactions against a transaction-level reference model.
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam int W  = 32;
    localparam int TO = 8;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [W-1:0] iaddr = '0, daddr = '0, dstore = '0;
    logic ihit, dhit, err, ramREN, ramWEN;
    logic [W-1:0] iload, dload, ramaddr, ramstore;
    logic [W-1:0] ramload = '0;
    logic [1:0] ramstate = 2'd0;

    int checks = 0;
    int failures = 0;

    int ram_lat = 1;
    logic [1:0] ram_resp = RS_ACCESS;
    logic [W-1:0] ram_data = '0;
    int ram_cnt = 0;

    typedef struct {
        logic ren, wen, ren_end;
        logic [W-1:0] addr, store, addr_end;
        int lat;
        logic ih, dh, er, wide;
    } obs_t;

    memory_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .err(err),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // RAM model: answers ram_resp on the ram_lat-th strobed cycle; BUSY otherwise.
    always @(negedge CLK) begin
        if (!(ramREN || ramWEN)) begin
            ram_cnt  <= 0;
            ramstate <= 2'd0;
            ramload  <= $urandom;
        end else if ((ram_cnt + 1 == ram_lat) && (ram_resp != RS_BUSY)) begin
            ram_cnt  <= ram_cnt + 1;
            ramstate <= ram_resp;
            ramload  <= ram_data;
        end else begin
            ram_cnt  <= ram_cnt + 1;
            ramstate <= RS_BUSY;
            ramload  <= $urandom;
        end
    end

    task automatic do_reset();
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic do_txn(input logic ir, input logic dr, input logic dw,
                          input logic [W-1:0] ia, input logic [W-1:0] da, input logic [W-1:0] ds,
                          input int lat, input logic [1:0] resp, input bit hold,
                          input logic [W-1:0] data, output obs_t o);
        int n;
        @(negedge CLK);
        iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
        ram_lat = lat; ram_resp = resp; ram_data = data;
        @(negedge CLK);
        o.ren = ramREN; o.wen = ramWEN; o.addr = ramaddr; o.store = ramstore;
        if (!hold) begin
            iREN = 0; dREN = 0; dWEN = 0;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom;
        end
        n = 0;
        while (!(ihit || dhit || err) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        o.lat = n; o.ih = ihit; o.dh = dhit; o.er = err;
        o.addr_end = ramaddr; o.ren_end = ramREN;
        iREN = 0; dREN = 0; dWEN = 0;
        @(negedge CLK);
        o.wide = ihit | dhit | err;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({ihit, dhit, err, ramREN, ramWEN} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b want=00000", {ihit, dhit, err, ramREN, ramWEN}); end
        checks++; if ({ramaddr, ramstore} !== '0) begin failures++; $display("FAIL reset_ram_bus got=%h/%h want=0/0", ramaddr, ramstore); end
        checks++; if ({iload, dload} !== '0) begin failures++; $display("FAIL reset_loads got=%h/%h want=0/0", iload, dload); end
    endtask

    task automatic test_ifetch();
        obs_t o;
        do_txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 2, RS_ACCESS, 1, 32'h2001_0005, o);
        checks++; if ({o.ren, o.wen} !== 2'b10) begin failures++; $display("FAIL ifetch_strobe got=%b want=10", {o.ren, o.wen}); end
        checks++; if (o.addr !== 32'h40) begin failures++; $display("FAIL ifetch_addr got=%h want=40", o.addr); end
        checks++; if ({o.ih, o.dh, o.er, o.wide} !== 4'b1000) begin failures++; $display("FAIL ifetch_hit got=%b want=1000", {o.ih, o.dh, o.er, o.wide}); end
        checks++; if (o.lat !== 2) begin failures++; $display("FAIL ifetch_latency got=%0d want=2", o.lat); end
        repeat (3) @(negedge CLK);
        checks++; if (iload !== 32'h2001_0005) begin failures++; $display("FAIL ifetch_iload_held got=%h want=20010005", iload); end
        checks++; if (dload !== 32'h0) begin failures++; $display("FAIL ifetch_dload got=%h want=0", dload); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] held;
        logic [W-1:0] exp_addr;
        logic exp_i, exp_d, exp_ren;
        do_reset();
        ram_lat = 1; ram_resp = RS_ACCESS; ram_data = 32'h0BAD_F00D;
        @(negedge CLK);
        iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h100;
        held = '0;
        // Grant on odd cycles, hit on even ones; data first, then alternate.
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k % 2 == 1) begin
                exp_addr = (k % 4 == 1) ? 32'h100 : 32'h40;
                held = exp_addr;
                exp_ren = 1; exp_i = 0; exp_d = 0;
            end else begin
                exp_addr = held;
                exp_ren = 0; exp_d = (k % 4 == 2); exp_i = !exp_d;
            end
            checks++;
            if ({ihit, dhit, ramREN, ramaddr} !== {exp_i, exp_d, exp_ren, exp_addr}) begin
                failures++;
                $display("FAIL b2b_cycle%0d got ihit=%b dhit=%b ren=%b addr=%h want %b %b %b %h",
                         k, ihit, dhit, ramREN, ramaddr, exp_i, exp_d, exp_ren, exp_addr);
            end
        end
        iREN = 0; dREN = 0;
        repeat (2) @(negedge CLK);
        checks++; if ({iload, dload} !== {32'h0BAD_F00D, 32'h0BAD_F00D}) begin failures++; $display("FAIL b2b_loads got=%h/%h want=0badf00d", iload, dload); end
    endtask

    task automatic test_write();
        obs_t o;
        do_reset();
        do_txn(0, 0, 1, 32'h0, 32'h200, 32'hDEAD_BEEF, 2, RS_ACCESS, 1, 32'h5555_AAAA, o);
        checks++; if ({o.ren, o.wen} !== 2'b01) begin failures++; $display("FAIL write_strobe got=%b want=01", {o.ren, o.wen}); end
        checks++; if ({o.addr, o.store} !== {32'h200, 32'hDEAD_BEEF}) begin failures++; $display("FAIL write_bus got=%h/%h want=200/deadbeef", o.addr, o.store); end
        checks++; if ({o.ih, o.dh, o.er, o.wide} !== 4'b0100) begin failures++; $display("FAIL write_hit got=%b want=0100", {o.ih, o.dh, o.er, o.wide}); end
        checks++; if (dload !== 32'h0) begin failures++; $display("FAIL write_dload got=%h want=0", dload); end
        do_txn(0, 1, 1, 32'h0, 32'h204, 32'h1234_0000, 1, RS_ACCESS, 1, 32'h7777_7777, o);
        checks++; if ({o.ren, o.wen, o.dh} !== 3'b011) begin failures++; $display("FAIL write_wins got=%b want=011", {o.ren, o.wen, o.dh}); end
        checks++; if (dload !== 32'h0) begin failures++; $display("FAIL write_wins_dload got=%h want=0", dload); end
    endtask

    task automatic test_drop();
        obs_t o;
        do_txn(0, 1, 0, 32'h0, 32'h300, 32'h0, 3, RS_ACCESS, 0, 32'h1234_5678, o);
        checks++; if ({o.dh, o.ih, o.er} !== 3'b100 || o.lat !== 3) begin failures++; $display("FAIL drop_hit got=%b lat=%0d want=100 lat=3", {o.dh, o.ih, o.er}, o.lat); end
        checks++; if (dload !== 32'h1234_5678) begin failures++; $display("FAIL drop_dload got=%h want=12345678", dload); end
        checks++; if (o.addr_end !== 32'h300) begin failures++; $display("FAIL drop_committed_addr got=%h want=300", o.addr_end); end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_reset();
        do_txn(1, 0, 0, 32'h44, 32'h0, 32'h0, 1, RS_BUSY, 1, 32'hFFFF_0000, o);
        checks++; if ({o.ih, o.dh, o.er, o.wide} !== 4'b0010) begin failures++; $display("FAIL timeout_err got=%b want=0010", {o.ih, o.dh, o.er, o.wide}); end
        checks++; if (o.lat !== TO) begin failures++; $display("FAIL timeout_latency got=%0d want=%0d", o.lat, TO); end
        checks++; if (o.ren_end !== 1'b0 || iload !== 32'h0) begin failures++; $display("FAIL timeout_idle got ren=%b iload=%h want 0/0", o.ren_end, iload); end
        do_txn(0, 1, 0, 32'h0, 32'h48, 32'h0, 1, RS_ERROR, 1, 32'hFFFF_0001, o);
        checks++; if ({o.ih, o.dh, o.er} !== 3'b001 || o.lat !== 1) begin failures++; $display("FAIL error_first got=%b lat=%0d want=001 lat=1", {o.ih, o.dh, o.er}, o.lat); end
        checks++; if (dload !== 32'h0) begin failures++; $display("FAIL error_dload got=%h want=0", dload); end
        do_txn(1, 0, 0, 32'h4C, 32'h0, 32'h0, TO, RS_ACCESS, 1, 32'hCAFE_0008, o);
        checks++; if ({o.ih, o.er} !== 2'b10 || o.lat !== TO || iload !== 32'hCAFE_0008) begin failures++; $display("FAIL access_beats_timeout got=%b lat=%0d iload=%h want=10 lat=%0d cafe0008", {o.ih, o.er}, o.lat, iload, TO); end
        do_txn(1, 0, 0, 32'h50, 32'h0, 32'h0, TO + 1, RS_ACCESS, 1, 32'hCAFE_0009, o);
        checks++; if ({o.ih, o.er} !== 2'b01 || o.lat !== TO || iload !== 32'hCAFE_0008) begin failures++; $display("FAIL access_too_late got=%b lat=%0d iload=%h want=01 lat=%0d cafe0008", {o.ih, o.er}, o.lat, iload, TO); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int n;
        do_txn(0, 1, 0, 32'h0, 32'h500, 32'h0, 1, RS_ACCESS, 1, 32'hAAAA_5555, o);
        @(negedge CLK);
        dREN = 1; daddr = 32'h600; ram_lat = 1; ram_resp = RS_BUSY;
        repeat (2) @(negedge CLK);
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin failures++; $display("FAIL rstmid_in_dreq got ren=%b addr=%h want 1/600", ramREN, ramaddr); end
        iREN = 1; iaddr = 32'h700;
        #2 nRST = 1'b0;
        #1;
        checks++; if ({ramREN, ramWEN, ihit, dhit, err} !== 5'b0) begin failures++; $display("FAIL rstmid_async got=%b want=00000", {ramREN, ramWEN, ihit, dhit, err}); end
        checks++; if (dload !== 32'h0) begin failures++; $display("FAIL rstmid_dload got=%h want=0", dload); end
        ram_lat = 2; ram_resp = RS_ACCESS; ram_data = 32'h6060_6060;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin failures++; $display("FAIL rstmid_regrant got ren=%b addr=%h want 1/600", ramREN, ramaddr); end
        n = 0;
        while (!(ihit || dhit || err) && n < 40) begin @(negedge CLK); n++; end
        checks++; if ({ihit, dhit, err} !== 3'b010 || n !== 2) begin failures++; $display("FAIL rstmid_hit got=%b lat=%0d want=010 lat=2", {ihit, dhit, err}, n); end
        iREN = 0; dREN = 0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_random();
        obs_t o;
        logic ir, dr, dw, gd, wr, ok;
        logic [W-1:0] ia, da, ds, data, ea;
        logic [1:0] resp;
        logic m_last;
        logic [W-1:0] m_il, m_dl;
        int lat, pat;
        do_reset();
        m_last = 0; m_il = '0; m_dl = '0;
        for (int t = 0; t < 60; t++) begin
            pat = $urandom_range(0, 3);
            ir = (pat == 0 || pat == 3);
            dr = (pat == 1) || (pat >= 2 && $urandom_range(0, 1) == 1);
            dw = (pat == 2) || (pat == 3 && !dr);
            ia = $urandom; da = $urandom; ds = $urandom; data = $urandom;
            lat = $urandom_range(1, 7);
            resp = ($urandom_range(0, 5) == 0) ? RS_ERROR : RS_ACCESS;
            do_txn(ir, dr, dw, ia, da, ds, lat, resp, bit'($urandom_range(0, 1)), data, o);
            gd = (dr || dw) && (!ir || !m_last);
            wr = gd && dw;
            ok = (resp == RS_ACCESS);
            ea = gd ? da : ia;
            m_last = gd;
            if (ok && !gd) m_il = data;
            if (ok && gd && !dw) m_dl = data;
            checks++; if ({o.ren, o.wen} !== {!wr, wr}) begin failures++; $display("FAIL rnd%0d_strobe got=%b want=%b", t, {o.ren, o.wen}, {!wr, wr}); end
            checks++; if (o.addr !== ea || o.addr_end !== ea) begin failures++; $display("FAIL rnd%0d_addr got=%h/%h want=%h", t, o.addr, o.addr_end, ea); end
            if (wr) begin
                checks++; if (o.store !== ds) begin failures++; $display("FAIL rnd%0d_store got=%h want=%h", t, o.store, ds); end
            end
            checks++; if ({o.ih, o.dh, o.er, o.wide} !== {ok && !gd, ok && gd, !ok, 1'b0}) begin failures++; $display("FAIL rnd%0d_pulse got=%b want=%b", t, {o.ih, o.dh, o.er, o.wide}, {ok && !gd, ok && gd, !ok, 1'b0}); end
            checks++; if (o.lat !== lat) begin failures++; $display("FAIL rnd%0d_latency got=%0d want=%0d", t, o.lat, lat); end
            checks++; if (iload !== m_il || dload !== m_dl) begin failures++; $display("FAIL rnd%0d_loads got=%h/%h want=%h/%h", t, iload, dload, m_il, m_dl); end
        end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_back_to_back();
        test_write();
        test_drop();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
